// File: rtl/imem_responder_pkg.sv
// Shared instruction-memory constants and the fetch-address fault rule, also used by
// the fetch unit when it checks redirect targets.
package imem_responder_pkg;

    localparam int unsigned INST_W      = 32;
    localparam int unsigned IMEM_IDX_LO = 2;
    localparam int unsigned IMEM_IDX_HI = 9;
    localparam int unsigned PC_MAX_W    = 64;

    // Narrower PCs are zero-extended by the caller before this check.
    function automatic logic imem_pc_fault(input logic [PC_MAX_W-1:0] pc);
        return (pc[IMEM_IDX_LO-1:0] != '0) || (pc[PC_MAX_W-1:IMEM_IDX_HI+1] != '0);
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Circular response FIFO with head/tail pointers, occupancy count and a single-cycle
// flush that drops every entry.
module imem_rsp_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 3,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full;
    logic             push_eff;
    logic             pop_eff;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full     = (count_q == CntW'(Depth));
    assign valid_o  = (count_q != '0);
    assign pop_eff  = pop_i && valid_o;
    assign push_eff = push_i && (!full || pop_eff);
    assign count_o  = count_q;
    // Empty buffer presents zeros rather than stale storage.
    assign rdata_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_eff)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({push_eff, pop_eff})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_eff && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CntW'(Depth));

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory: one-stage synchronous read feeding a small response
// buffer, with redirect flush and an independent loader write port.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BUF_DEPTH = 3,
    parameter string       INIT_FILE = ""
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_pc,
    output logic [INST_W-1:0] rsp_inst,
    output logic              rsp_fault,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [31:0]       wr_data
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned EntW = XLEN + INST_W + 1;
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [INST_W-1:0] rdata_q;
    logic [IdxW-1:0]   req_idx;
    logic              req_fire;

    logic              s1_valid_q, s1_valid_d;
    logic [XLEN-1:0]   s1_pc_q, s1_pc_d;
    logic              s1_fault_q, s1_fault_d;
    logic [INST_W-1:0] s1_inst;

    logic [EntW-1:0]   fifo_wdata;
    logic [EntW-1:0]   fifo_rdata;
    logic [CntW-1:0]   fifo_count;

    assign req_idx  = IdxW'(req_pc[IMEM_IDX_HI:IMEM_IDX_LO]);
    // S1 counts as outstanding, so a request is only taken when its slot is guaranteed.
    assign req_ready = !flush && ((32'(fifo_count) + 32'(s1_valid_q)) < BUF_DEPTH);
    assign req_fire  = req_valid && req_ready;

    // Non-blocking write gives read-first behaviour on a same-word collision.
    always_ff @(posedge sys_clk) begin
        if (wr_en)    mem_q[IdxW'(wr_addr)] <= wr_data;
        if (req_fire) rdata_q <= mem_q[req_idx];
    end

    always_comb begin
        s1_valid_d = req_fire && !flush;
        s1_pc_d    = s1_pc_q;
        s1_fault_d = s1_fault_q;
        if (req_fire) begin
            s1_pc_d    = req_pc;
            s1_fault_d = imem_pc_fault(PC_MAX_W'(req_pc));
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            s1_fault_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pc_q    <= s1_pc_d;
            s1_fault_q <= s1_fault_d;
        end
    end

    assign s1_inst    = s1_fault_q ? '0 : rdata_q;
    assign fifo_wdata = {s1_pc_q, s1_inst, s1_fault_q};

    imem_rsp_fifo #(
        .Width (EntW),
        .Depth (BUF_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst),
        .flush_i (flush),
        .push_i  (s1_valid_q && !flush),
        .wdata_i (fifo_wdata),
        .pop_i   (rsp_ready),
        .valid_o (rsp_valid),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign rsp_pc    = fifo_rdata[EntW-1 -: XLEN];
    assign rsp_inst  = fifo_rdata[INST_W:1];
    assign rsp_fault = fifo_rdata[0];

endmodule

// File: tb/tb_imem_responder.sv
// Randomised and directed checks of imem_responder against a transaction-level model:
// a queue of accepted fetches plus a shadow copy of the instruction store.
module tb_imem_responder;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
        int unsigned e;
    } ent_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_pc;
    logic [31:0] rsp_inst;
    logic        rsp_fault;
    logic        flush;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    int          total = 0;
    int          bad = 0;
    int unsigned ec = 0;
    int          pops = 0;
    logic        last_acc;
    logic        last_pop;
    ent_t        q[$];
    logic [31:0] smem [256];

    always #5 sys_clk = ~sys_clk;

    imem_responder dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_pc    (rsp_pc),
        .rsp_inst  (rsp_inst),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    function automatic logic mfault(input logic [63:0] pc);
        return (pc % 4 != 0) || (pc >= 64'h400);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model over the rising edge.
    task automatic tick();
        logic exp_v;
        ent_t n;
        @(negedge sys_clk);
        last_acc = req_valid && req_ready;
        chk("req_ready", {63'd0, req_ready}, {63'd0, !flush && (q.size() < 3)});
        exp_v = (q.size() > 0) && (q[0].e < ec);
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_v});
        if (rsp_valid && exp_v) begin
            chk("rsp_pc", rsp_pc, q[0].pc);
            chk("rsp_inst", {32'd0, rsp_inst}, {32'd0, q[0].inst});
            chk("rsp_fault", {63'd0, rsp_fault}, {63'd0, q[0].fault});
        end
        last_pop = rsp_valid && rsp_ready && exp_v;
        @(posedge sys_clk);
        ec++;
        if (last_pop) begin
            void'(q.pop_front());
            pops++;
        end
        if (flush) begin
            q.delete();
        end else if (last_acc) begin
            n.pc    = req_pc;
            n.fault = mfault(req_pc);
            n.inst  = n.fault ? 32'd0 : smem[req_pc[9:2]];
            n.e     = ec;
            q.push_back(n);
        end
        if (wr_en) smem[wr_addr] = wr_data;
        #1;
    endtask

    task automatic req1(input logic [63:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wr1(input logic [7:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 12 && q.size() > 0; i++) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] bp_pc [4];
        int          n;
        int          first_pop;
        int          acc_at;
        int          p0;

        sys_rst   = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_pc", rsp_pc, 64'd0);
        chk("rst_rsp_inst", {32'd0, rsp_inst}, 64'd0);
        chk("rst_rsp_fault", {63'd0, rsp_fault}, 64'd0);
        sys_rst = 1'b1;

        for (int i = 0; i < 256; i++) wr1(8'(i), $urandom);

        // Streaming
        wr1(8'd0, 32'h0000_0013);
        wr1(8'd1, 32'h0010_0093);
        wr1(8'd2, 32'h0020_0113);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_pc = 64'h0; tick();
        req_pc = 64'h4; tick();
        req_pc = 64'h8; tick();
        drain();

        // Backpressure: 3 accepted, 4th waits for the first pop
        bp_pc[0] = 64'h10; bp_pc[1] = 64'h14; bp_pc[2] = 64'h18; bp_pc[3] = 64'h1c;
        rsp_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_pc    = bp_pc[n];
            tick();
            if (last_acc) n++;
        end
        chk("bp_accepted", 64'(n), 64'd3);
        chk("bp_stall", {63'd0, req_ready}, 64'd0);
        rsp_ready = 1'b1;
        first_pop = -1;
        acc_at    = -1;
        for (int i = 0; i < 8 && n < 4; i++) begin
            req_pc = bp_pc[n];
            tick();
            if (last_pop && first_pop < 0) first_pop = i;
            if (last_acc) begin
                acc_at = i;
                n++;
            end
        end
        chk("bp_resume_gap", 64'(acc_at - first_pop), 64'd1);
        drain();

        // Flush with 2 buffered and S1 valid
        rsp_ready = 1'b0;
        req1(64'h20);
        req1(64'h24);
        req1(64'h28);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        p0 = pops;
        rsp_ready = 1'b1;
        req1(64'h40);
        drain();
        chk("flush_pops", 64'(pops - p0), 64'd1);

        // Faults and the top word
        req1(64'h6);
        req1(64'h400);
        req1(64'h3fc);
        drain();

        // Read-first collision
        wr1(8'd5, 32'hAAAA_0005);
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hBBBB_0005;
        req1(64'h14);
        wr_en = 1'b0;
        req1(64'h14);
        drain();

        // Asynchronous reset mid-burst
        rsp_ready = 1'b0;
        req1(64'h30);
        req1(64'h34);
        tick();
        sys_rst = 1'b0;
        #1;
        chk("amid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("amid_req_ready", {63'd0, req_ready}, 64'd1);
        q.delete();
        #1;
        sys_rst = 1'b1;
        tick();
        tick();
        rsp_ready = 1'b1;
        req1(64'h0);
        drain();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            req_valid = ($urandom_range(3) != 0);
            req_pc    = ($urandom_range(15) == 0) ? {$urandom, $urandom}
                                                  : {54'd0, 8'($urandom), 2'b00};
            rsp_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(24) == 0);
            wr_en     = ($urandom_range(4) == 0);
            wr_addr   = 8'($urandom);
            wr_data   = $urandom;
            tick();
        end
        flush = 1'b0;
        wr_en = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
